// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order credit-limited fetches
// to instruction memory and buffers returned instructions for decode.
// Outstanding requests plus buffered entries never exceed FIFO_DEPTH. A fetch
// slot is therefore always reserved for every response, so responses need no
// backpressure. A redirect reloads the PC, flushes the buffer and arranges for
// every response still in flight to be dropped when it returns.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH   = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc
);

  localparam int             PW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW:0]    L_DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] L_INSTR_BYTES = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_rsp_pc;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_outstanding;
  logic [CW-1:0]       r_drop;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic [PC_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]         r_fifo_instr [FIFO_DEPTH];

  logic [CW:0]         w_credit_used;
  logic                w_req_valid;
  logic                w_req_fire;
  logic                w_rsp_ok;
  logic                w_rsp_push;
  logic                w_pop;
  logic [CW-1:0]       w_outstanding_next;

  // Credit, handshake and response classification.
  always_comb begin
    w_credit_used = {1'b0, r_outstanding} + {1'b0, r_count};
    // Gated by rst_n so no request is presented while reset is held.
    w_req_valid   = rst_n && !redirect_valid && (w_credit_used < L_DEPTH);
    w_req_fire    = w_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    w_rsp_ok      = imem_rsp_valid && (r_outstanding != '0);
    w_rsp_push    = w_rsp_ok && (r_drop == '0) && !redirect_valid;
    w_pop         = (r_count != '0) && id_ready && !redirect_valid;
    w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_ok);
  end

  // PC, response-PC, counters and pointers; redirect overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (redirect_valid) begin
      r_pc          <= redirect_pc;
      r_rsp_pc      <= redirect_pc;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_outstanding <= w_outstanding_next;
      // Everything still in flight belongs to the old stream; this also
      // covers back-to-back redirects since drop never exceeds outstanding.
      r_drop        <= w_outstanding_next;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_req_fire) begin
        r_pc <= r_pc + L_INSTR_BYTES;
      end
      if (w_rsp_ok && (r_drop != '0)) begin
        r_drop <= r_drop - 1'b1;
      end
      if (w_rsp_push) begin
        r_rsp_pc <= r_rsp_pc + L_INSTR_BYTES;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_rsp_push) - CW'(w_pop);
    end
  end

  // Buffer storage; contents are only observed through a non-zero count,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_rsp_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
      r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
    end
  end

  // Decode-side outputs, forced to zero while the buffer is empty.
  always_comb begin
    imem_req_valid = w_req_valid;
    imem_req_addr  = r_pc;
    id_valid       = (r_count != '0);
    id_instr       = id_valid ? r_fifo_instr[r_rd_ptr] : '0;
    id_pc          = id_valid ? r_fifo_pc[r_rd_ptr]    : '0;
  end

endmodule
